clrled_fader: RTL and testbench
===============================

// Module: clrled_fader
// PURPOSE
//  Sequencer for the board's colour-LED PWM cores. Holds a bus-writable target
//  colour per LED and steps each displayed colour toward its target at a
//  programmable rate. Drives each PWM core's write strobe/data pair. Generates
//  the shared 9-bit PWM counter. Sits behind fastio on the WB bus; one
//  o_clr_stb bit per PWM core, one o_clr_data bus shared by all cores.
// PARAMETERS
//  NLEDS        4         number of colour LEDs sequenced (1..4)
//  DEFAULT_DIV  16'd5000  reset value of the fade-step divider (clocks per step)
// PORTS
//  i_clk        in   1          system clock
//  i_reset      in   1          synchronous, active-high reset
//  i_wb_stb     in   1          bus strobe, one access per cycle
//  i_wb_we      in   1          1 = write
//  i_wb_addr    in   3          register select
//  i_wb_data    in   32         write data
//  o_wb_ack     out  1          one cycle after i_wb_stb
//  o_wb_stall   out  1          tied 0
//  o_wb_data    out  32         read data, valid with o_wb_ack
//  o_clr_stb    out  NLEDS      per-LED write strobe to the PWM core
//  o_clr_data   out  32         colour word for the strobed core
//  o_counter    out  9          shared free-running PWM counter
//  o_busy       out  1          any LED not yet at its target
// BEHAVIOUR
//  Colour word: r={d[26],d[23:16]}, g={d[25],d[15:8]}, b={d[24],d[7:0]};
//   bits 31:27 read 0. Each channel is 9-bit unsigned.
//  Registers:
//   - addr 0..NLEDS-1: W sets target[n] and dirty[n]; R returns current[n].
//   - addr 4: control. bit31 = fade_en, bits15:0 = div. R returns {fade_en,15'h0,div}.
//   - addr 5: status. R returns {28'h0, dirty[3:0]}.
//   - Other addresses: writes ignored, reads 0. LEDs >= NLEDS read 0 and never strobe.
//  Reset: all outputs 0. target/current = 0, fade_en = 0, div = DEFAULT_DIV,
//   tick counter = 0, state = WAIT. dirty[] = all 1, so the first sweep pushes
//   0 to every core. Reset mid-sweep aborts the sweep; no further strobes follow.
//  o_counter: increments every clock, wraps 511 -> 0.
//  FSM:
//   - WAIT: tick counter counts down. At 0 it reloads from div and goes to SWEEP
//     with idx = 0. div = 0 means a tick every WAIT cycle.
//   - SWEEP: one LED per clock, idx 0..NLEDS-1, then back to WAIT.
//  Per-LED step in SWEEP (using current[idx] and target[idx]):
//   - fade_en = 0: next = target.
//   - fade_en = 1: each channel moves +-1 toward target, or holds if equal.
//     It never overshoots; 0 and 511 are never crossed.
//   - If next != current or dirty[idx]: current <= next, o_clr_stb[idx] <= 1,
//     o_clr_data <= next in colour-word format. Else no strobe.
//   - dirty[idx] clears when next == target.
//  o_clr_stb is registered and one-hot-or-zero, high for exactly 1 cycle per
//   strobe. o_clr_data holds its last value when no strobe is issued.
//   LED n strobes n+1 clocks after the WAIT->SWEEP tick.
//  Bus write to target[idx] in the same cycle SWEEP processes idx:
//   - the step uses the old target;
//   - the new target and dirty = 1 take effect at the next sweep (the write wins
//     over the dirty clear).
//  Register write to addr 4 mid-sweep: the new fade_en/div apply from the next
//   LED step and the next reload respectively.
//  o_busy = |dirty[NLEDS-1:0], registered.
// TESTING
//  - Reset, then run 2 sweeps (div=0) -> exactly one strobe per LED, data 0,
//    o_busy falls; o_counter reads 9 after 9 clocks.
//  - fade_en=0, write 0x07_00_00 to addr 1 -> o_clr_stb=4'b0010 with data
//    0x00070000 on the next sweep, then no further strobes.
//  - fade_en=1, div=3, target0 = 0x0FF_FFFF from 0 -> current0 red/green/blue
//    each +1 every 4+NLEDS clocks; 255 strobes; current0 reads 0x00FFFFFF; status 0.
//  - fade_en=1, target 0x0000010 from current 0x4000000 -> r MSB-channel counts
//    down 256..0 while b counts up 0..16 then holds; no overshoot.
//  - Write target2 in the exact cycle idx=2 is stepped -> old target used;
//    dirty[2] remains 1; the new value is strobed on the following sweep.
//  - Assert i_reset during SWEEP at idx=1 -> no strobe for idx 2..3; outputs 0
//    next cycle; re-init sweep pushes 0 to all cores.

Source files
------------

// File: rtl/clrled_fader_if.sv
// Wishbone-style register bus between the fastio decoder and the colour-LED fader.
// The master drives the strobe, write enable, address and write data. The slave returns ack, stall and read data.
interface clrled_fader_if;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [2:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );

    modport slave (
        input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/clrled_fader.sv
// Colour-LED fade sequencer: steps each displayed colour toward its bus-written
// target once per sweep and strobes the changed colour word into that LED's PWM core.
module clrled_fader #(
    parameter int          NLEDS       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd5000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    clrled_fader_if.slave      wb,
    output logic [NLEDS-1:0]   o_clr_stb,
    output logic [31:0]        o_clr_data,
    output logic [8:0]         o_counter,
    output logic               o_busy
);

    typedef enum logic [0:0] {ST_WAIT, ST_SWEEP} state_t;

    localparam logic [1:0] LAST_IDX  = 2'(NLEDS - 1);
    localparam logic [2:0] LED_LIMIT = 3'(NLEDS);
    localparam logic [3:0] LED_MASK  = 4'((1 << NLEDS) - 1);

    // Colours are kept in the packed 27-bit word layout: {r8,g8,b8,r[7:0],g[7:0],b[7:0]}
    function automatic logic [8:0] step_chan(input logic [8:0] cur, input logic [8:0] tgt);
        logic [8:0] res;
        if (cur < tgt) begin
            res = cur + 9'd1;
        end else if (cur > tgt) begin
            res = cur - 9'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    function automatic logic [26:0] step_colour(input logic [26:0] cur, input logic [26:0] tgt);
        logic [8:0] r;
        logic [8:0] g;
        logic [8:0] b;
        r = step_chan({cur[26], cur[23:16]}, {tgt[26], tgt[23:16]});
        g = step_chan({cur[25], cur[15:8]},  {tgt[25], tgt[15:8]});
        b = step_chan({cur[24], cur[7:0]},   {tgt[24], tgt[7:0]});
        return {r[8], g[8], b[8], r[7:0], g[7:0], b[7:0]};
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [1:0]  idx_r;
    logic [1:0]  idx_nx_s;
    logic [15:0] tick_r;
    logic [15:0] tick_nx_s;
    logic        fade_en_r;
    logic [15:0] div_r;
    logic [3:0]  dirty_r;
    logic [26:0] target_r  [0:3];
    logic [26:0] current_r [0:3];

    logic        wr_s;
    logic        sweep_s;
    logic [26:0] cur_sel_s;
    logic [26:0] tgt_sel_s;
    logic [26:0] next_col_s;
    logic        change_s;
    logic        settled_s;
    logic [31:0] rd_s;
    logic        unused_s;

    assign wr_s          = wb.i_wb_stb & wb.i_wb_we;
    assign wb.o_wb_stall = 1'b0;
    assign unused_s      = ^wb.i_wb_data[30:27];

    // Next-state, sweep index and tick-counter logic
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        tick_nx_s  = tick_r;
        case (state_r)
            ST_WAIT: begin
                if (tick_r == 16'd0) begin
                    state_nx_s = ST_SWEEP;
                    idx_nx_s   = 2'd0;
                    tick_nx_s  = div_r;
                end else begin
                    tick_nx_s  = tick_r - 16'd1;
                end
            end
            ST_SWEEP: begin
                if (idx_r == LAST_IDX) begin
                    state_nx_s = ST_WAIT;
                    idx_nx_s   = 2'd0;
                end else begin
                    idx_nx_s   = idx_r + 2'd1;
                end
            end
            default: begin
                state_nx_s = ST_WAIT;
                idx_nx_s   = 2'd0;
            end
        endcase
    end

    // Per-LED step for the LED currently selected by the sweep
    always_comb begin
        sweep_s   = (state_r == ST_SWEEP);
        cur_sel_s = current_r[idx_r];
        tgt_sel_s = target_r[idx_r];
        if (fade_en_r) begin
            next_col_s = step_colour(cur_sel_s, tgt_sel_s);
        end else begin
            next_col_s = tgt_sel_s;
        end
        change_s  = sweep_s && ((next_col_s != cur_sel_s) || dirty_r[idx_r]);
        settled_s = sweep_s && (next_col_s == tgt_sel_s);
    end

    // Register read multiplexer
    always_comb begin
        rd_s = 32'h0000_0000;
        case (wb.i_wb_addr)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                if (wb.i_wb_addr < LED_LIMIT) begin
                    rd_s = {5'd0, current_r[wb.i_wb_addr[1:0]]};
                end else begin
                    rd_s = 32'h0000_0000;
                end
            end
            3'd4:    rd_s = {fade_en_r, 15'h0000, div_r};
            3'd5:    rd_s = {28'h000_0000, dirty_r};
            default: rd_s = 32'h0000_0000;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_WAIT;
            idx_r   <= 2'd0;
            tick_r  <= 16'd0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            tick_r  <= tick_nx_s;
        end
    end

    // Colour datapath, control registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fade_en_r    <= 1'b0;
            div_r        <= DEFAULT_DIV;
            dirty_r      <= LED_MASK;
            for (int n = 0; n < 4; n++) begin
                target_r[n]  <= 27'd0;
                current_r[n] <= 27'd0;
            end
            o_clr_stb    <= '0;
            o_clr_data   <= 32'h0000_0000;
            o_counter    <= 9'd0;
            o_busy       <= 1'b0;
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= 32'h0000_0000;
        end else begin
            o_counter <= o_counter + 9'd1;
            o_busy    <= |dirty_r;

            if (change_s) begin
                current_r[idx_r] <= next_col_s;
                o_clr_stb        <= NLEDS'(1'b1) << idx_r;
                o_clr_data       <= {5'd0, next_col_s};
            end else begin
                o_clr_stb        <= '0;
            end

            if (settled_s) begin
                dirty_r[idx_r] <= 1'b0;
            end

            // Placed after the settle clear so a same-cycle target write keeps dirty set
            if (wr_s && (wb.i_wb_addr < LED_LIMIT)) begin
                target_r[wb.i_wb_addr[1:0]] <= wb.i_wb_data[26:0];
                dirty_r[wb.i_wb_addr[1:0]]  <= 1'b1;
            end

            if (wr_s && (wb.i_wb_addr == 3'd4)) begin
                fade_en_r <= wb.i_wb_data[31];
                div_r     <= wb.i_wb_data[15:0];
            end

            wb.o_wb_ack <= wb.i_wb_stb;
            if (wb.i_wb_stb && !wb.i_wb_we) begin
                wb.o_wb_data <= rd_s;
            end else begin
                wb.o_wb_data <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_clrled_fader.sv
// Scoreboard bench for clrled_fader: expected strobes are queued as targets are
// written and matched against every strobe the fader issues.
module tb_clrled_fader;

    localparam int NLEDS = 4;

    typedef struct {
        int          led;
        logic [31:0] data;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [NLEDS-1:0] clr_stb;
    logic [31:0]      clr_data;
    logic [8:0]       counter;
    logic             busy;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    bit   chk_period = 1'b0;
    bit   have_prev  = 1'b0;
    int   last0      = 0;

    clrled_fader_if bus ();

    clrled_fader #(.NLEDS(NLEDS), .DEFAULT_DIV(16'd7)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .wb         (bus),
        .o_clr_stb  (clr_stb),
        .o_clr_data (clr_data),
        .o_counter  (counter),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input int led, input logic [31:0] d);
        exp_t e;
        e.led  = led;
        e.data = d;
        sb_q.push_back(e);
    endfunction

    // Strobe monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (clr_stb != 4'd0) begin
            if (sb_q.size() == 0) begin
                check_eq("unexp_stb", {28'd0, clr_stb}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("stb_led", {28'd0, clr_stb}, 32'd1 << mon_e.led);
                check_eq("stb_data", clr_data, mon_e.data);
            end
            if (chk_period && clr_stb[0]) begin
                if (have_prev) check_eq("fade_period", cyc - last0, 32'd8);
                have_prev = 1'b1;
                last0     = cyc;
            end
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        @(negedge clk);
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = a;
        @(negedge clk);
        bus.i_wb_stb  = 1'b0;
        check_eq({tag, "_ack"}, {31'd0, bus.o_wb_ack}, 32'd1);
        check_eq(tag, bus.o_wb_data, exp);
    endtask

    task automatic drain(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, sb_q.size(), 32'd0);
    endtask

    task automatic wait_stb(input int led, input int max_cyc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (clr_stb[led]) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          r;
        int          b;

        rst           = 1'b1;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = 3'd0;
        bus.i_wb_data = 32'd0;

        // Reset state and the initial sweep that pushes 0 to every core
        for (int n = 0; n < NLEDS; n++) push_exp(n, 32'h0000_0000);
        repeat (3) @(negedge clk);
        check_eq("rst_stb",     {28'd0, clr_stb}, 32'd0);
        check_eq("rst_data",    clr_data, 32'd0);
        check_eq("rst_counter", {23'd0, counter}, 32'd0);
        check_eq("rst_busy",    {31'd0, busy}, 32'd0);
        check_eq("rst_ack",     {31'd0, bus.o_wb_ack}, 32'd0);
        rst = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("counter_9", {23'd0, counter}, 32'd9);
        drain(20, "init_drain");
        repeat (15) @(negedge clk);
        check_eq("init_busy", {31'd0, busy}, 32'd0);
        bus_read(3'd4, 32'h0000_0007, "ctrl_rst");
        bus_read(3'd5, 32'h0000_0000, "status_rst");

        // Immediate update, exactly one strobe
        bus_write(3'd4, 32'h0000_0000);
        push_exp(1, 32'h0007_0000);
        bus_write(3'd1, 32'h0007_0000);
        drain(40, "jump_drain");
        repeat (20) @(negedge clk);
        bus_read(3'd1, 32'h0007_0000, "cur1_jump");
        bus_read(3'd6, 32'h0000_0000, "addr6_read");

        // Fade LED0 from black to 0x0FFFFFF at div=3
        for (int k = 1; k <= 255; k++) begin
            d = 32'(k);
            push_exp(0, (d << 16) | (d << 8) | d);
        end
        have_prev  = 1'b0;
        chk_period = 1'b1;
        bus_write(3'd4, 32'h8000_0003);
        bus_write(3'd0, 32'h00FF_FFFF);
        drain(255 * 8 + 100, "fade_up_drain");
        chk_period = 1'b0;
        bus_read(3'd0, 32'h00FF_FFFF, "cur0_fade");
        bus_read(3'd5, 32'h0000_0000, "status_fade");
        bus_read(3'd4, 32'h8000_0003, "ctrl_fade");

        // Red MSB channel fades down past 256 while blue rises and holds at 16
        bus_write(3'd4, 32'h0000_0000);
        push_exp(3, 32'h0400_0000);
        bus_write(3'd3, 32'h0400_0000);
        drain(60, "preset3_drain");
        for (int k = 1; k <= 256; k++) begin
            r = 256 - k;
            b = (k < 16) ? k : 16;
            push_exp(3, (32'(r >> 8) << 26) | (32'(r & 255) << 16) | 32'(b));
        end
        bus_write(3'd4, 32'h8000_0000);
        bus_write(3'd3, 32'h0000_0010);
        drain(256 * 5 + 100, "fade_dn_drain");
        bus_read(3'd3, 32'h0000_0010, "cur3_fade");

        // Target write in the same cycle the sweep steps that LED
        bus_write(3'd4, 32'h0000_0000);
        push_exp(1, 32'h0000_0055);
        bus_write(3'd1, 32'h0000_0055);
        wait_stb(1, 50, "sync_led1");
        push_exp(2, 32'h0000_00AA);
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = 3'd2;
        bus.i_wb_data = 32'h0000_00AA;
        @(negedge clk);
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        check_eq("collide_nostb", {28'd0, clr_stb}, 32'd0);
        bus_read(3'd5, 32'h0000_0004, "status_collide");
        check_eq("busy_pending", {31'd0, busy}, 32'd1);
        drain(40, "collide_drain");
        bus_read(3'd2, 32'h0000_00AA, "cur2_collide");

        // Reset while the sweep is at idx 1 aborts the remaining strobes
        bus_write(3'd4, 32'h0000_0014);
        push_exp(3, 32'h0000_0123);
        bus_write(3'd3, 32'h0000_0123);
        wait_stb(3, 60, "sync_led3");
        push_exp(0, 32'h0000_0111);
        bus_write(3'd0, 32'h0000_0111);
        bus_write(3'd1, 32'h0000_0222);
        bus_write(3'd2, 32'h0000_0333);
        bus_write(3'd3, 32'h0000_0444);
        wait_stb(0, 40, "sync_led0");
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_stb",     {28'd0, clr_stb}, 32'd0);
        check_eq("mid_rst_data",    clr_data, 32'd0);
        check_eq("mid_rst_counter", {23'd0, counter}, 32'd0);
        check_eq("mid_rst_busy",    {31'd0, busy}, 32'd0);
        for (int n = 0; n < NLEDS; n++) push_exp(n, 32'h0000_0000);
        rst = 1'b0;
        drain(30, "reinit_drain");
        repeat (20) @(negedge clk);
        check_eq("reinit_busy", {31'd0, busy}, 32'd0);
        bus_read(3'd4, 32'h0000_0007, "ctrl_reinit");
        bus_read(3'd1, 32'h0000_0000, "cur1_reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
